// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key-code constants and entry FSM state encoding for the
// hex keypad entry block (keypad_entry, key_edge).
package keypad_pkg;

  // Codes 0-15 are hex digits (bit 4 clear); 16 and up are control keys.
  localparam logic [4:0] KEY_BKSP  = 5'd16;
  localparam logic [4:0] KEY_CLR   = 5'd17;
  localparam logic [4:0] KEY_ENTER = 5'd18;

  typedef enum logic {
    S_ENTRY = 1'b0,   // collecting digits
    S_HOLD  = 1'b1    // committed word waiting for the consumer
  } state_e;

  function automatic logic is_digit(input logic [4:0] code);
    return !code[4];
  endfunction

endpackage

// File: rtl/key_edge.sv
// key_edge: turns the level keystrobe into a single-cycle key event.
//
// Ports
//   clk        in   clock
//   rst        in   async active-high reset
//   keystrobe  in   high while a key is held
//   event_o    out  high for the one cycle in which a new press is sampled
//
// Build option: KEYPAD_DEBOUNCE_EN adds a lockout counter that blocks new
// events for DEBOUNCE_CYCLES clocks after each event. Without it, every
// rising edge of keystrobe is an event.
module key_edge #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic keystrobe,
  output logic event_o
);

  logic strobe_q;
  logic rise;
  logic locked;

  // History resets to 1 so a key held through reset is not a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) strobe_q <= 1'b1;
    else     strobe_q <= keystrobe;
  end

  assign rise = keystrobe & ~strobe_q;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int LOCK_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(DEBOUNCE_CYCLES);

  logic [LOCK_W-1:0] lock_q, lock_d;

  // Reloads on each event and counts down to zero; runs regardless of what
  // the entry FSM does with the event.
  always_comb begin
    lock_d = lock_q;
    if (event_o)            lock_d = LOCK_LOAD;
    else if (lock_q != '0)  lock_d = lock_q - LOCK_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_q <= '0;
    else     lock_q <= lock_d;
  end

  assign locked = (lock_q != '0);
`else
  // No lockout in this build; the expression is constant 0 for any legal
  // lockout length.
  assign locked = (DEBOUNCE_CYCLES < 0);
`endif

  assign event_o = rise & ~locked;

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: hex keypad entry buffer with commit handshake.
//
// Digits shift in from the right into a 32-bit buffer (up to MAX_DIGITS),
// BKSP drops the last digit, CLR empties the buffer, ENTER commits a non-empty
// buffer to data_out and waits in HOLD until the consumer takes it
// (data_valid && data_ready). Key events are ignored while in HOLD.
//
// Ports
//   clk          in   clock
//   rst          in   async active-high reset
//   keycode[4:0] in   0-15 digit, 16 BKSP, 17 CLR, 18 ENTER, others ignored
//   keystrobe    in   high while a key is held
//   value[31:0]  out  live entry buffer
//   digit_count  out  digits held
//   overflow     out  sticky: digit dropped on full buffer
//   data_out     out  committed word
//   data_valid   out  committed word available
//   data_ready   in   consumer accepts data_out
//
// Build option: KEYPAD_DEBOUNCE_EN enables the post-key lockout in key_edge.
module keypad_entry #(
  parameter int MAX_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  keycode,
  input  logic        keystrobe,
  output logic [31:0] value,
  output logic [3:0]  digit_count,
  output logic        overflow,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready
);
  import keypad_pkg::*;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_e      state_q, state_d;
  logic        key_ev;
  logic        entry_ev;
  logic        commit;
  logic [31:0] value_q, value_d;
  logic [31:0] dout_q, dout_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  key_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_edge (
    .clk       (clk),
    .rst       (rst),
    .keystrobe (keystrobe),
    .event_o   (key_ev)
  );

  assign entry_ev = key_ev && (state_q == S_ENTRY);
  assign commit   = entry_ev && (keycode == KEY_ENTER) && (cnt_q != 4'd0);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_ENTRY;
    else     state_q <= state_d;
  end

  // FSM: next state. In HOLD, data_valid is asserted, so data_ready alone
  // completes the handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ENTRY: if (commit)     state_d = S_HOLD;
      S_HOLD:  if (data_ready) state_d = S_ENTRY;
      default:                 state_d = S_ENTRY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    value       = value_q;
    digit_count = cnt_q;
    overflow    = ovf_q;
    data_out    = dout_q;
    data_valid  = (state_q == S_HOLD);
  end

  // Buffer update. A digit only shifts in while count < MAX_DIGITS, so bits
  // above 4*MAX_DIGITS are never written and stay zero.
  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dout_d  = dout_q;
    if (entry_ev) begin
      if (is_digit(keycode)) begin
        if (cnt_q < MAX_CNT) begin
          value_d = {value_q[27:0], keycode[3:0]};
          cnt_d   = cnt_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        case (keycode)
          KEY_BKSP: if (cnt_q != 4'd0) begin
            value_d = value_q >> 4;
            cnt_d   = cnt_q - 4'd1;
          end
          KEY_CLR: begin
            value_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
          KEY_ENTER: if (cnt_q != 4'd0) begin
            dout_d  = value_q;
            value_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;

  localparam int MAXD = 8;
  localparam int DEB  = 20;
  localparam int GAP  = 24;   // idle cycles after each press, longer than the lockout

  logic        clk, rst;
  logic [4:0]  keycode;
  logic        keystrobe;
  logic [31:0] value;
  logic [3:0]  digit_count;
  logic        overflow;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_entry #(
    .MAX_DIGITS      (MAXD),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keycode     (keycode),
    .keystrobe   (keystrobe),
    .value       (value),
    .digit_count (digit_count),
    .overflow    (overflow),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One press: strobe high across one rising edge, then released.
  task automatic press(input logic [4:0] code);
    @(negedge clk); keycode = code; keystrobe = 1'b1;
    @(negedge clk); keystrobe = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; keystrobe = 1'b0; keycode = '0; data_ready = 1'b0;
    #1;
    n_checks++; if (value !== 32'h0) begin n_fail++; $display("FAIL reset_value: got %h want %h", value, 32'h0); end
    n_checks++; if (digit_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", digit_count); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", data_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_entry;
    press(5'd1); press(5'd2); press(5'd10); press(5'd3);
    n_checks++; if (value !== 32'h12A3) begin n_fail++; $display("FAIL entry_value: got %h want %h", value, 32'h12A3); end
    n_checks++; if (digit_count !== 4'd4) begin n_fail++; $display("FAIL entry_count: got %0d want 4", digit_count); end
    press(5'd18);
    n_checks++; if (data_out !== 32'h000012A3) begin n_fail++; $display("FAIL entry_dout: got %h want %h", data_out, 32'h12A3); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL entry_valid: got %b want 1", data_valid); end
    n_checks++; if (value !== 32'h0) begin n_fail++; $display("FAIL entry_value_clr: got %h want 0", value); end
    n_checks++; if (digit_count !== 4'd0) begin n_fail++; $display("FAIL entry_count_clr: got %0d want 0", digit_count); end
    data_ready = 1'b1;
    @(negedge clk); data_ready = 1'b0;
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL entry_accept: got %b want 0", data_valid); end
  endtask

  task automatic test_overflow;
    for (int d = 1; d <= 9; d++) press(5'(d));
    n_checks++; if (value !== 32'h12345678) begin n_fail++; $display("FAIL ovf_value: got %h want %h", value, 32'h12345678); end
    n_checks++; if (digit_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", digit_count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    press(5'd17);
    n_checks++; if (value !== 32'h0) begin n_fail++; $display("FAIL clr_value: got %h want 0", value); end
    n_checks++; if (digit_count !== 4'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", digit_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_bksp;
    press(5'd15); press(5'd14);
    n_checks++; if (value !== 32'hFE) begin n_fail++; $display("FAIL bksp_fe: got %h want fe", value); end
    press(5'd16);
    n_checks++; if (value !== 32'hF || digit_count !== 4'd1) begin n_fail++; $display("FAIL bksp_f: got %h/%0d want f/1", value, digit_count); end
    press(5'd16);
    n_checks++; if (value !== 32'h0 || digit_count !== 4'd0) begin n_fail++; $display("FAIL bksp_0: got %h/%0d want 0/0", value, digit_count); end
    press(5'd16);
    n_checks++; if (value !== 32'h0 || digit_count !== 4'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL bksp_empty: got %h/%0d/%b want 0/0/0", value, digit_count, overflow); end
    press(5'd18);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL enter_empty: got %b want 0", data_valid); end
    press(5'd19);
    n_checks++; if (value !== 32'h0 || digit_count !== 4'd0) begin n_fail++; $display("FAIL key19: got %h/%0d want 0/0", value, digit_count); end
  endtask

  task automatic test_hold;
    data_ready = 1'b0;
    press(5'd5); press(5'd18);
    press(5'd7);
    repeat (10) @(negedge clk);
    n_checks++; if (data_out !== 32'h5) begin n_fail++; $display("FAIL hold_dout: got %h want 5", data_out); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b want 1", data_valid); end
    n_checks++; if (value !== 32'h0 || digit_count !== 4'd0) begin n_fail++; $display("FAIL hold_value: got %h/%0d want 0/0", value, digit_count); end
    // key press on the handshake cycle itself must be dropped
    data_ready = 1'b1; keycode = 5'd7; keystrobe = 1'b1;
    @(negedge clk); data_ready = 1'b0; keystrobe = 1'b0;
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL hold_accept: got %b want 0", data_valid); end
    n_checks++; if (value !== 32'h0) begin n_fail++; $display("FAIL hold_hs_key: got %h want 0", value); end
    repeat (GAP) @(negedge clk);
    press(5'd7);
    n_checks++; if (value !== 32'h7 || digit_count !== 4'd1) begin n_fail++; $display("FAIL hold_after: got %h/%0d want 7/1", value, digit_count); end
  endtask

  task automatic test_debounce;
    logic [31:0] exp_mid, exp_end;
    logic [3:0]  exp_cnt;
`ifdef KEYPAD_DEBOUNCE_EN
    exp_mid = 32'h1; exp_end = 32'h13; exp_cnt = 4'd2;
`else
    exp_mid = 32'h12; exp_end = 32'h123; exp_cnt = 4'd3;
`endif
    press(5'd17);
    @(negedge clk); keycode = 5'd1; keystrobe = 1'b1;   // sampled at edge 0
    @(negedge clk); keystrobe = 1'b0;
    repeat (9) @(negedge clk);
    keycode = 5'd2; keystrobe = 1'b1;                   // sampled at edge 10
    @(negedge clk); keystrobe = 1'b0;
    n_checks++; if (value !== exp_mid) begin n_fail++; $display("FAIL deb_edge10: got %h want %h", value, exp_mid); end
    repeat (14) @(negedge clk);
    keycode = 5'd3; keystrobe = 1'b1;                   // sampled at edge 25
    @(negedge clk); keystrobe = 1'b0;
    repeat (GAP) @(negedge clk);
    n_checks++; if (value !== exp_end || digit_count !== exp_cnt) begin n_fail++; $display("FAIL deb_edge25: got %h/%0d want %h/%0d", value, digit_count, exp_end, exp_cnt); end
  endtask

  task automatic test_reset_mid;
    press(5'd17); press(5'd10); press(5'd11);
    n_checks++; if (value !== 32'hAB) begin n_fail++; $display("FAIL mid_value: got %h want ab", value); end
    @(negedge clk); keycode = 5'd5; keystrobe = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (value !== 32'h0 || digit_count !== 4'd0) begin n_fail++; $display("FAIL mid_rst_value: got %h/%0d want 0/0", value, digit_count); end
    n_checks++; if (data_out !== 32'h0 || data_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got %h/%b/%b want 0/0/0", data_out, data_valid, overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (value !== 32'h0 || digit_count !== 4'd0) begin n_fail++; $display("FAIL mid_held_key: got %h/%0d want 0/0", value, digit_count); end
    keystrobe = 1'b0;
    @(negedge clk);
    press(5'd5);
    n_checks++; if (value !== 32'h5 || digit_count !== 4'd1) begin n_fail++; $display("FAIL mid_repress: got %h/%0d want 5/1", value, digit_count); end
  endtask

  initial begin
    test_reset;
    test_entry;
    test_overflow;
    test_bksp;
    test_hold;
    test_debounce;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 8, maximum hex digits held (legal 1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000, lockout length in clocks after an accepted key (legal >=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port keycode  input  5  encoded key from the upstream key synchroniser: 0-15 hex digit, 16 BKSP, 17 CLR, 18 ENTER, 19 reserved.
REQ-006 SHALL have port keystrobe  input  1  level high while any key is held; delayed so keycode is stable when it rises.
REQ-007 SHALL have port value  output  32  live entry buffer, right-aligned hex digits, for display.
REQ-008 SHALL have port digit_count  output  4  digits currently held (0..MAX_DIGITS).
REQ-009 SHALL have port overflow  output  1  sticky: a digit was dropped because the buffer was full.
REQ-010 SHALL have port data_out  output  32  committed word, valid while data_valid=1.
REQ-011 SHALL have port data_valid  output  1  committed word available.
REQ-012 SHALL have port data_ready  input  1  consumer accepts data_out.

Function
REQ-013 SHALL register keystrobe; key event = keystrobe=1 with previous sample 0; keycode sampled on the same edge; state reflects the event in the next cycle (1-cycle latency).
REQ-014 SHALL run FSM ENTRY -> HOLD on ENTER with digit_count>0; HOLD -> ENTRY on a data_valid&&data_ready cycle.
REQ-015 SHALL, in ENTRY, on digit d with count<MAX_DIGITS: value={value[27:0],d}, count+1.
REQ-016 SHALL, on digit with count==MAX_DIGITS: value/count unchanged, overflow set.
REQ-017 SHALL, on BKSP: value logically shifted right 4, count-1; at count 0, no-op.
REQ-018 SHALL, on CLR: value=0, count=0, overflow=0.
REQ-019 SHALL, on ENTER with count 0, take no action; code 19 always ignored.
REQ-020 SHALL, on ENTER with count>0: data_out=value, data_valid=1, value=0, count=0, overflow=0.
REQ-021 SHALL hold data_out and data_valid stable in HOLD until the handshake completes; data_valid drops the cycle after acceptance.
REQ-022 SHALL ignore all key events while in HOLD, including an event on the handshake cycle.
REQ-023 SHALL keep value bits above 4*MAX_DIGITS at zero.

Reset
REQ-024 SHALL, on rst=1 (asynchronous, any time including mid-entry or HOLD): FSM=ENTRY, value=0, digit_count=0, overflow=0, data_out=0, data_valid=0, strobe history=1 (a key held through reset does not count as an event), lockout counter=0.

Configuration
REQ-025 SHALL, with KEYPAD_DEBOUNCE_EN defined, ignore key events for DEBOUNCE_CYCLES clocks after each accepted event; the lockout counter is also active in HOLD.
REQ-026 SHALL, without KEYPAD_DEBOUNCE_EN, omit the counter and accept every qualifying rising edge; DEBOUNCE_CYCLES is unused.

Structure
REQ-027 SHALL place key-code constants (KEY_BKSP=16, KEY_CLR=17, KEY_ENTER=18) and the FSM state enum in shared package keypad_pkg.
REQ-028 SHALL implement edge detection plus optional lockout in sub-module key_edge (inputs clk, rst, keystrobe; output 1-cycle event pulse).

Verification
REQ-029 Keys 1,2,A,3 then ENTER -> value 0x12A3 count 4 before ENTER; data_out=0x000012A3, data_valid=1, value=0.
REQ-030 Nine digits 1..9 at MAX_DIGITS=8 -> value 0x12345678, count 8, overflow=1; CLR -> all 0.
REQ-031 Keys F,E,BKSP,BKSP,BKSP -> value 0xFE, then 0xF, then 0, count stays 0, no error.
REQ-032 ENTER 0x5 with data_ready=0 for 10 cycles while pressing 7 -> data_out stays 0x5, value stays 0; data_ready=1 -> data_valid low next cycle, next 7 accepted.
REQ-033 Debounce enabled, DEBOUNCE_CYCLES=20: second strobe edge 10 cycles after the first ignored, edge at 25 cycles accepted; disabled: both accepted.
REQ-034 rst pulsed mid-entry (value 0xAB) with keystrobe held high -> all outputs 0 immediately; no event registered after rst drops until keystrobe falls and rises again.
